// File: rtl/mem_tag_responder_pkg.sv
// mem_tag_responder_pkg
//   Shared types for the proc2mem/mem2proc tagged memory protocol: tag,
//   block and address types, the command encoding, the number of usable
//   tags, and the layout of one pending-response entry.
//   Ports: none (package).
package mem_tag_responder_pkg;

  // Tags 1..15 are usable; tag 0 means "none" on every tag output.
  localparam int MEM_NUM_TAGS = 15;

  typedef logic [3:0]  mem_tag_t;
  typedef logic [63:0] mem_block_t;
  typedef logic [31:0] addr_t;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'b00,
    MEM_LOAD  = 2'b01,
    MEM_STORE = 2'b10
  } mem_command_e;

  typedef struct packed {
    logic       valid;
    logic       is_load;
    logic [7:0] countdown;
    mem_block_t data;
  } mem_resp_entry_t;

endpackage

// File: rtl/mem_tag_responder_if.sv
// mem_tag_responder_if
//   Bundles the proc2mem request and mem2proc response signals.
//   master modport: requester (cache/MSHR side) drives proc2mem_*.
//   slave modport : memory responder drives mem2proc_*.
interface mem_tag_responder_if;
  import mem_tag_responder_pkg::*;

  mem_command_e proc2mem_command;
  addr_t        proc2mem_addr;
  mem_block_t   proc2mem_data;
  mem_tag_t     mem2proc_transaction_tag;
  mem_block_t   mem2proc_data;
  mem_tag_t     mem2proc_data_tag;

  modport master (
    output proc2mem_command, proc2mem_addr, proc2mem_data,
    input  mem2proc_transaction_tag, mem2proc_data, mem2proc_data_tag
  );

  modport slave (
    input  proc2mem_command, proc2mem_addr, proc2mem_data,
    output mem2proc_transaction_tag, mem2proc_data, mem2proc_data_tag
  );

endinterface

// File: rtl/mem_tag_pool.sv
// mem_tag_pool
//   Free bitmap for tags 1..MEM_NUM_TAGS with lowest-free selection.
//   Ports:
//     clock, reset_n   clock and asynchronous active-low reset (all tags free)
//     alloc_en         allocate grant_tag at the next edge
//     release_mask     tags to return to the pool at the next edge
//     grant_tag        lowest free tag, 0 when none is free
//   A released tag only becomes grantable after the edge that frees it,
//   because grant_tag is computed from the registered bitmap.
module mem_tag_pool
  import mem_tag_responder_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  alloc_en,
  input  logic [MEM_NUM_TAGS:1] release_mask,
  output mem_tag_t              grant_tag
);

  logic [MEM_NUM_TAGS:1] free_q, free_d;

  // Scan high to low so the lowest free tag is the last one written.
  always_comb begin
    grant_tag = '0;
    for (int t = MEM_NUM_TAGS; t >= 1; t--) begin
      if (free_q[t]) grant_tag = mem_tag_t'(t);
    end
  end

  always_comb begin
    free_d = free_q | release_mask;
    if (alloc_en && grant_tag != '0) free_d[grant_tag] = 1'b0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) free_q <= '1;
    else          free_q <= free_d;
  end

endmodule

// File: rtl/mem_tag_responder.sv
// mem_tag_responder
//   Memory end of the proc2mem/mem2proc protocol. Accepts one LOAD/STORE per
//   cycle, acknowledges it combinationally with the lowest free tag, and
//   returns load data with its tag exactly LATENCY cycles after acceptance.
//   Ports:
//     clock, reset_n   clock and asynchronous active-low reset
//     bus (slave)      proc2mem_command/addr/data in;
//                      mem2proc_transaction_tag (comb), mem2proc_data and
//                      mem2proc_data_tag (registered) out
//   Optional feature macro: MEM_RESP_STALL_EN -- rejects every request seen
//   while a mod-STALL_PERIOD request counter is 0.
//   The backing store is not reset.
module mem_tag_responder
  import mem_tag_responder_pkg::*;
#(
  parameter int LATENCY         = 10,
  parameter int MEM_SIZE_BLOCKS = 8192,
  parameter int STALL_PERIOD    = 4
) (
  input logic                clock,
  input logic                reset_n,
  mem_tag_responder_if.slave bus
);

  localparam int         IDX_W   = $clog2(MEM_SIZE_BLOCKS);
  localparam logic [7:0] CD_INIT = 8'(LATENCY - 1);

  if (LATENCY < 1 || LATENCY > 255 || STALL_PERIOD < 2) begin : g_param_check
    $error("mem_tag_responder: LATENCY must be 1..255 and STALL_PERIOD >= 2");
  end

  logic [IDX_W-1:0]      idx;
  mem_block_t            mem_q [MEM_SIZE_BLOCKS];
  mem_block_t            rd_data;
  mem_tag_t              grant_tag;
  logic                  req, is_load, stall, accept;
  logic [MEM_NUM_TAGS:1] release_mask;

  mem_resp_entry_t entry_q [1:MEM_NUM_TAGS];
  mem_resp_entry_t entry_d [1:MEM_NUM_TAGS];
  mem_tag_t        rsp_tag_q, rsp_tag_d;
  mem_block_t      rsp_data_q, rsp_data_d;

  // Offset bits and bits above the store depth are don't-care (address wraps).
  logic unused_addr;
  assign unused_addr = ^{bus.proc2mem_addr[31:3+IDX_W], bus.proc2mem_addr[2:0]};

  assign idx     = bus.proc2mem_addr[3 +: IDX_W];
  assign rd_data = mem_q[idx];
  assign is_load = (bus.proc2mem_command == MEM_LOAD);
  assign req     = is_load || (bus.proc2mem_command == MEM_STORE);
  assign accept  = reset_n && req && (grant_tag != '0) && !stall;

  assign bus.mem2proc_transaction_tag = accept ? grant_tag : '0;
  assign bus.mem2proc_data            = rsp_data_q;
  assign bus.mem2proc_data_tag        = rsp_tag_q;

  mem_tag_pool u_tag_pool (
    .clock        (clock),
    .reset_n      (reset_n),
    .alloc_en     (accept),
    .release_mask (release_mask),
    .grant_tag    (grant_tag)
  );

`ifdef MEM_RESP_STALL_EN
  localparam int STALL_W = $clog2(STALL_PERIOD);
  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;

  // Advances on every request cycle, accepted or not, so rejections land
  // on a fixed cadence regardless of tag availability.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (req) begin
      stall_cnt_d = (stall_cnt_q == STALL_W'(STALL_PERIOD - 1)) ? '0 : stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) stall_cnt_q <= '0;
    else          stall_cnt_q <= stall_cnt_d;
  end

  assign stall = (stall_cnt_q == '0);
`else
  assign stall = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (accept && !is_load) mem_q[idx] <= bus.proc2mem_data;
  end

  // A load entry's countdown is the number of edges still to pass before the
  // edge that loads the response register; it expires when that count is 1.
  // Store entries live for one cycle only, to hold their tag until release.
  // The tag on data_tag is released at the edge that clears it.
  always_comb begin
    entry_d      = entry_q;
    rsp_tag_d    = '0;
    rsp_data_d   = rsp_data_q;
    release_mask = '0;

    if (rsp_tag_q != '0) release_mask[rsp_tag_q] = 1'b1;

    for (int t = 1; t <= MEM_NUM_TAGS; t++) begin
      if (entry_q[t].valid) begin
        if (!entry_q[t].is_load) begin
          release_mask[t]  = 1'b1;
          entry_d[t].valid = 1'b0;
        end else if (entry_q[t].countdown == 8'd1) begin
          rsp_tag_d        = mem_tag_t'(t);
          rsp_data_d       = entry_q[t].data;
          entry_d[t].valid = 1'b0;
        end else begin
          entry_d[t].countdown = entry_q[t].countdown - 8'd1;
        end
      end
    end

    if (accept) begin
      if (is_load && LATENCY == 1) begin
        // Single-cycle latency: response goes straight into the register.
        rsp_tag_d  = grant_tag;
        rsp_data_d = rd_data;
      end else begin
        entry_d[grant_tag].valid     = 1'b1;
        entry_d[grant_tag].is_load   = is_load;
        entry_d[grant_tag].countdown = CD_INIT;
        entry_d[grant_tag].data      = rd_data;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      entry_q    <= '{default: '0};
      rsp_tag_q  <= '0;
      rsp_data_q <= '0;
    end else begin
      entry_q    <= entry_d;
      rsp_tag_q  <= rsp_tag_d;
      rsp_data_q <= rsp_data_d;
    end
  end

endmodule

// File: tb/tb_mem_tag_responder.sv
module tb_mem_tag_responder;
  import mem_tag_responder_pkg::*;

  logic clock   = 1'b0;
  logic reset_n = 1'b1;
  always #5 clock = ~clock;

  mem_tag_responder_if bus   ();
  mem_tag_responder_if bus20 ();

  mem_tag_responder #(.LATENCY(10), .MEM_SIZE_BLOCKS(8192), .STALL_PERIOD(4)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  mem_tag_responder #(.LATENCY(20), .MEM_SIZE_BLOCKS(8192), .STALL_PERIOD(4)) dut20 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus20)
  );

  int total = 0;
  int bad   = 0;

  mem_tag_t   exp_tag, exp_dt;
  mem_block_t exp_data;

  task automatic drv(input mem_command_e cmd, input addr_t a, input mem_block_t d);
    bus.proc2mem_command = cmd;
    bus.proc2mem_addr    = a;
    bus.proc2mem_data    = d;
  endtask

  task automatic drv20(input mem_command_e cmd, input addr_t a);
    bus20.proc2mem_command = cmd;
    bus20.proc2mem_addr    = a;
    bus20.proc2mem_data    = '0;
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Store one word, then idle long enough for its tag to be free again.
  task automatic preload(input addr_t a, input mem_block_t d);
    drv(MEM_STORE, a, d);
    tick;
    drv(MEM_NONE, '0, '0);
    tick;
    tick;
  endtask

  task automatic test_reset;
    drv(MEM_LOAD, 32'h0, '0);
    drv20(MEM_LOAD, 32'h0);
    #1 reset_n = 1'b0;
    #2;
    total++; if (bus.mem2proc_transaction_tag !== 4'd0) begin bad++; $display("FAIL rst_ttag got=%0d exp=0", bus.mem2proc_transaction_tag); end
    total++; if (bus.mem2proc_data_tag !== 4'd0) begin bad++; $display("FAIL rst_dtag got=%0d exp=0", bus.mem2proc_data_tag); end
    total++; if (bus.mem2proc_data !== 64'd0) begin bad++; $display("FAIL rst_data got=%h exp=0", bus.mem2proc_data); end
    total++; if (bus20.mem2proc_transaction_tag !== 4'd0) begin bad++; $display("FAIL rst_ttag20 got=%0d exp=0", bus20.mem2proc_transaction_tag); end
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    drv(MEM_NONE, '0, '0);
    drv20(MEM_NONE, '0);
    tick;
  endtask

  task automatic test_single_load;
    mem_block_t w;
    w = 64'hDEAD_BEEF_0123_4567;
    preload(32'h800, w);
    for (int c = 0; c <= 12; c++) begin
      if (c == 0) drv(MEM_LOAD, 32'h800, '0);
      else        drv(MEM_NONE, '0, '0);
      @(negedge clock);
      exp_tag = (c == 0) ? 4'd1 : 4'd0;
      exp_dt  = (c == 10) ? 4'd1 : 4'd0;
      total++; if (bus.mem2proc_transaction_tag !== exp_tag) begin bad++; $display("FAIL single_ttag c=%0d got=%0d exp=%0d", c, bus.mem2proc_transaction_tag, exp_tag); end
      total++; if (bus.mem2proc_data_tag !== exp_dt) begin bad++; $display("FAIL single_dtag c=%0d got=%0d exp=%0d", c, bus.mem2proc_data_tag, exp_dt); end
      if (c == 10) begin
        total++; if (bus.mem2proc_data !== w) begin bad++; $display("FAIL single_data got=%h exp=%h", bus.mem2proc_data, w); end
      end
      tick;
    end
  endtask

  task automatic test_back_to_back;
    mem_block_t w0, w1, w2;
    addr_t      a;
    w0 = 64'hA0A0_0000_0000_0001;
    w1 = 64'hA1A1_0000_0000_0002;
    w2 = 64'hA2A2_0000_0000_0003;
    preload(32'h0, w0);
    preload(32'h8, w1);
    preload(32'h10, w2);
    for (int c = 0; c <= 14; c++) begin
      // Third load uses an address above the store depth; it wraps to block 2.
      a = (c == 0) ? 32'h0 : (c == 1) ? 32'h8 : 32'h0001_0010;
      if (c < 3) drv(MEM_LOAD, a, '0);
      else       drv(MEM_NONE, '0, '0);
      @(negedge clock);
      exp_tag  = (c < 3) ? mem_tag_t'(c + 1) : 4'd0;
      exp_dt   = (c >= 10 && c <= 12) ? mem_tag_t'(c - 9) : 4'd0;
      exp_data = (c == 10) ? w0 : (c == 11) ? w1 : w2;
      total++; if (bus.mem2proc_transaction_tag !== exp_tag) begin bad++; $display("FAIL b2b_ttag c=%0d got=%0d exp=%0d", c, bus.mem2proc_transaction_tag, exp_tag); end
      total++; if (bus.mem2proc_data_tag !== exp_dt) begin bad++; $display("FAIL b2b_dtag c=%0d got=%0d exp=%0d", c, bus.mem2proc_data_tag, exp_dt); end
      if (exp_dt != 4'd0) begin
        total++; if (bus.mem2proc_data !== exp_data) begin bad++; $display("FAIL b2b_data c=%0d got=%h exp=%h", c, bus.mem2proc_data, exp_data); end
      end
      tick;
    end
  endtask

  task automatic test_exhaustion;
    for (int c = 0; c <= 21; c++) begin
      drv20(MEM_LOAD, addr_t'(c * 8));
      @(negedge clock);
      exp_tag = (c < 15) ? mem_tag_t'(c + 1) : (c == 21) ? 4'd1 : 4'd0;
      exp_dt  = (c >= 20) ? mem_tag_t'(c - 19) : 4'd0;
      total++; if (bus20.mem2proc_transaction_tag !== exp_tag) begin bad++; $display("FAIL exh_ttag c=%0d got=%0d exp=%0d", c, bus20.mem2proc_transaction_tag, exp_tag); end
      total++; if (bus20.mem2proc_data_tag !== exp_dt) begin bad++; $display("FAIL exh_dtag c=%0d got=%0d exp=%0d", c, bus20.mem2proc_data_tag, exp_dt); end
      tick;
    end
    drv20(MEM_NONE, '0);
  endtask

  task automatic test_store_load;
    for (int c = 0; c <= 25; c++) begin
      case (c)
        0:       drv(MEM_STORE, 32'h40, 64'h1111);
        1:       drv(MEM_LOAD,  32'h40, '0);
        2:       drv(MEM_STORE, 32'h40, 64'h2222);
        14:      drv(MEM_LOAD,  32'h40, '0);
        default: drv(MEM_NONE,  '0, '0);
      endcase
      @(negedge clock);
      exp_tag  = (c == 1) ? 4'd2 : (c == 0 || c == 2 || c == 14) ? 4'd1 : 4'd0;
      exp_dt   = (c == 11) ? 4'd2 : (c == 24) ? 4'd1 : 4'd0;
      exp_data = (c == 11) ? 64'h1111 : 64'h2222;
      total++; if (bus.mem2proc_transaction_tag !== exp_tag) begin bad++; $display("FAIL st_ttag c=%0d got=%0d exp=%0d", c, bus.mem2proc_transaction_tag, exp_tag); end
      total++; if (bus.mem2proc_data_tag !== exp_dt) begin bad++; $display("FAIL st_dtag c=%0d got=%0d exp=%0d", c, bus.mem2proc_data_tag, exp_dt); end
      if (exp_dt != 4'd0) begin
        total++; if (bus.mem2proc_data !== exp_data) begin bad++; $display("FAIL st_data c=%0d got=%h exp=%h", c, bus.mem2proc_data, exp_data); end
      end
      tick;
    end
  endtask

  task automatic test_reset_midflight;
    for (int c = 0; c <= 19; c++) begin
      if (c < 3)       drv(MEM_LOAD, addr_t'(c * 8), '0);
      else if (c == 5) drv(MEM_LOAD, 32'h0, '0);
      else if (c == 8) drv(MEM_LOAD, 32'h0, '0);
      else             drv(MEM_NONE, '0, '0);
      if (c == 5) begin
        reset_n = 1'b0;
        #1;
        total++; if (bus.mem2proc_data_tag !== 4'd0) begin bad++; $display("FAIL mid_rst_dtag got=%0d exp=0", bus.mem2proc_data_tag); end
        total++; if (bus.mem2proc_data !== 64'd0) begin bad++; $display("FAIL mid_rst_data got=%h exp=0", bus.mem2proc_data); end
      end
      @(negedge clock);
      exp_tag = (c < 3) ? mem_tag_t'(c + 1) : (c == 8) ? 4'd1 : 4'd0;
      exp_dt  = (c == 18) ? 4'd1 : 4'd0;
      total++; if (bus.mem2proc_transaction_tag !== exp_tag) begin bad++; $display("FAIL mid_ttag c=%0d got=%0d exp=%0d", c, bus.mem2proc_transaction_tag, exp_tag); end
      total++; if (bus.mem2proc_data_tag !== exp_dt) begin bad++; $display("FAIL mid_dtag c=%0d got=%0d exp=%0d", c, bus.mem2proc_data_tag, exp_dt); end
      if (c == 18) begin
        total++; if (bus.mem2proc_data !== 64'hA0A0_0000_0000_0001) begin bad++; $display("FAIL mid_data got=%h exp=a0a0000000000001", bus.mem2proc_data); end
      end
      if (c == 6) reset_n = 1'b1;
      tick;
    end
  endtask

  task automatic test_stall;
    int  n_acc;
    bit  rej;
    reset_n = 1'b0;
    #2;
    @(negedge clock);
    reset_n = 1'b1;
    tick;
    n_acc = 0;
    for (int c = 0; c <= 9; c++) begin
      drv(MEM_LOAD, addr_t'(c * 8), '0);
      @(negedge clock);
`ifdef MEM_RESP_STALL_EN
      rej = (c % 4 == 0);
`else
      rej = 1'b0;
`endif
      exp_tag = rej ? 4'd0 : mem_tag_t'(n_acc + 1);
      if (!rej) n_acc++;
      total++; if (bus.mem2proc_transaction_tag !== exp_tag) begin bad++; $display("FAIL stall_ttag c=%0d got=%0d exp=%0d", c, bus.mem2proc_transaction_tag, exp_tag); end
      total++; if (bus.mem2proc_data_tag !== 4'd0) begin bad++; $display("FAIL stall_dtag c=%0d got=%0d exp=0", c, bus.mem2proc_data_tag); end
      tick;
    end
    drv(MEM_NONE, '0, '0);
    repeat (15) tick;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_single_load;
    test_back_to_back;
    test_exhaustion;
    test_store_load;
    test_reset_midflight;
    test_stall;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
